conv_ff_bank: RTL and testbench

- WIDTH-bit register bank. Every bit is built as a T flip-flop core with per-mode conversion logic in front of it.
- The bank can be configured at run time to behave as D, T, JK or SR flip-flops.
- The mode is held in an internal register and changed with a one-cycle write strobe.
- Includes a sticky SR-illegal-input flag and an output change strobe. Used as a configurable state/flag register in control paths.

---
 rtl/ff_pkg.sv | 25 ++
 rtl/t_ff_cell.sv | 23 ++
 rtl/conv_ff_bank.sv | 98 +++++++++
 tb/tb_conv_ff_bank.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ff_pkg.sv
// Shared mode encoding and per-bit toggle conversion for the configurable flip-flop bank.
package ff_pkg;

    typedef logic [1:0] ff_mode_t;

    localparam ff_mode_t MODE_D  = 2'd0;
    localparam ff_mode_t MODE_T  = 2'd1;
    localparam ff_mode_t MODE_JK = 2'd2;
    localparam ff_mode_t MODE_SR = 2'd3;

    // Converts D/T/JK/SR inputs into the toggle request of a T flip-flop core.
    // In SR mode a=b=1 yields no toggle, so an illegal bit simply holds.
    function automatic logic conv_toggle(input ff_mode_t m, input logic a, input logic b,
                                         input logic q);
        logic t;
        case (m)
            MODE_D:  t = a ^ q;
            MODE_T:  t = a;
            MODE_JK: t = (a & ~q) | (b & q);
            default: t = (a & ~b & ~q) | (b & ~a & q);
        endcase
        return t;
    endfunction

endpackage

// File: rtl/t_ff_cell.sv
// Single-bit T flip-flop with clock enable and a reset value supplied as an input.
module t_ff_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic rst_val,
    input  logic t,
    output logic q
);

    logic q_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= rst_val;
        end else if (en && t) begin
            q_q <= ~q_q;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/conv_ff_bank.sv
// Run-time configurable D/T/JK/SR register bank built from T flip-flop cells.
// Optional saturating change counter on output toggle_cnt when TOGGLE_CNT_EN is defined.
module conv_ff_bank
    import ff_pkg::*;
#(
    parameter int                WIDTH    = 8,
    parameter logic [WIDTH-1:0]  RST_VAL  = {WIDTH{1'b0}},
    parameter ff_mode_t          RST_MODE = MODE_D
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode_wr,
    input  logic [1:0]       mode_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic [1:0]       mode,
    output logic             sr_err,
    output logic             chg
`ifdef TOGGLE_CNT_EN
    ,
    output logic [15:0]      toggle_cnt
`endif
);

    ff_mode_t        mode_q, mode_d;
    logic            sr_err_q, sr_err_d;
    logic            chg_q, chg_d;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] sr_illegal;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign t[i] = conv_toggle(mode_q, a[i], b[i], q[i]);

        t_ff_cell u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
            .rst_val (RST_VAL[i]),
            .t       (t[i]),
            .q       (q[i])
        );
    end

    always_comb begin
        q_next     = en ? (q ^ t) : q;
        sr_illegal = (en && (mode_q == MODE_SR)) ? (a & b) : '0;
        chg_d      = |(q_next ^ q);
        mode_d     = mode_wr ? ff_mode_t'(mode_in) : mode_q;
        // A new illegal input on a clearing edge keeps the flag set.
        sr_err_d   = (|sr_illegal) | (sr_err_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= RST_MODE;
            sr_err_q <= 1'b0;
            chg_q    <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            sr_err_q <= sr_err_d;
            chg_q    <= chg_d;
        end
    end

`ifdef TOGGLE_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_err) begin
            cnt_d = 16'h0000;
        end else if (chg_d && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'h0001;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'h0000;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign toggle_cnt = cnt_q;
`endif

    assign qn     = ~q;
    assign mode   = mode_q;
    assign sr_err = sr_err_q;
    assign chg    = chg_q;

endmodule

// File: tb/tb_conv_ff_bank.sv
// Directed bench for conv_ff_bank: 8-bit bank plus 1-bit and 32-bit all-ones-reset builds.
module tb_conv_ff_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        mode_wr;
    logic [1:0]  mode_in;
    logic        clr_err;
    logic [7:0]  a8, b8;
    logic [7:0]  q8, qn8;
    logic [1:0]  mode8;
    logic        sr_err8, chg8;
    logic [0:0]  a1, b1, q1, qn1;
    logic [1:0]  mode1;
    logic        sr_err1, chg1;
    logic [31:0] a32, b32, q32, qn32;
    logic [1:0]  mode32;
    logic        sr_err32, chg32;
`ifdef TOGGLE_CNT_EN
    logic [15:0] cnt8, cnt1, cnt32;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    conv_ff_bank dut8 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode_wr(mode_wr), .mode_in(mode_in),
        .a(a8), .b(b8), .clr_err(clr_err), .q(q8), .qn(qn8), .mode(mode8),
        .sr_err(sr_err8), .chg(chg8)
`ifdef TOGGLE_CNT_EN
        , .toggle_cnt(cnt8)
`endif
    );

    conv_ff_bank #(.WIDTH(1), .RST_VAL(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode_wr(mode_wr), .mode_in(mode_in),
        .a(a1), .b(b1), .clr_err(clr_err), .q(q1), .qn(qn1), .mode(mode1),
        .sr_err(sr_err1), .chg(chg1)
`ifdef TOGGLE_CNT_EN
        , .toggle_cnt(cnt1)
`endif
    );

    conv_ff_bank #(.WIDTH(32), .RST_VAL(32'hFFFF_FFFF)) dut32 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode_wr(mode_wr), .mode_in(mode_in),
        .a(a32), .b(b32), .clr_err(clr_err), .q(q32), .qn(qn32), .mode(mode32),
        .sr_err(sr_err32), .chg(chg32)
`ifdef TOGGLE_CNT_EN
        , .toggle_cnt(cnt32)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; mode_wr = 1'b0; mode_in = 2'd0; clr_err = 1'b0;
        a8 = 8'h00; b8 = 8'h00; a1 = 1'b0; b1 = 1'b0; a32 = '0; b32 = '0;
        step(); step();
        rst_n = 1'b1;
        mode_wr = 1'b1; mode_in = 2'd1; a8 = 8'hFF; en = 1'b1;
        step();
        mode_wr = 1'b0;
        n_checks++;
        if (q8 !== 8'hFF || mode8 !== 2'd1) begin
            n_fail++;
            $display("FAIL pre_reset_state: q=%h mode=%0d, expected q=ff mode=1", q8, mode8);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (q8 !== 8'h00 || qn8 !== 8'hFF || mode8 !== 2'd0 || sr_err8 !== 1'b0 || chg8 !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: q=%h qn=%h mode=%0d sr_err=%b chg=%b, expected 00 ff 0 0 0",
                     q8, qn8, mode8, sr_err8, chg8);
        end
        mode_wr = 1'b1; mode_in = 2'd3;
        step();
        mode_wr = 1'b0; a8 = 8'h00;
        rst_n = 1'b1;
        step();
        n_checks++;
        if (mode8 !== 2'd0 || q8 !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_drops_mode_wr: mode=%0d q=%h, expected mode=0 q=00", mode8, q8);
        end
    endtask

    task automatic test_d_mode();
        a8 = 8'hA5; en = 1'b1;
        step();
        n_checks++;
        if (q8 !== 8'hA5 || qn8 !== 8'h5A || chg8 !== 1'b1) begin
            n_fail++;
            $display("FAIL d_load: q=%h qn=%h chg=%b, expected a5 5a 1", q8, qn8, chg8);
        end
        step();
        n_checks++;
        if (q8 !== 8'hA5 || chg8 !== 1'b0) begin
            n_fail++;
            $display("FAIL d_hold_chg: q=%h chg=%b, expected a5 0", q8, chg8);
        end
    endtask

    task automatic test_t_mode();
        mode_wr = 1'b1; mode_in = 2'd1; a8 = 8'hFF;
        step();
        mode_wr = 1'b0;
        n_checks++;
        if (q8 !== 8'hFF || mode8 !== 2'd1 || chg8 !== 1'b1) begin
            n_fail++;
            $display("FAIL t_write_old_mode: q=%h mode=%0d chg=%b, expected ff 1 1", q8, mode8, chg8);
        end
        a8 = 8'h5A;
        step();
        n_checks++;
        if (q8 !== 8'hA5) begin
            n_fail++;
            $display("FAIL t_toggle1: q=%h, expected a5", q8);
        end
        a8 = 8'h0F;
        step();
        n_checks++;
        if (q8 !== 8'hAA) begin
            n_fail++;
            $display("FAIL t_toggle2: q=%h, expected aa", q8);
        end
        en = 1'b0; a8 = 8'hFF;
        step();
        n_checks++;
        if (q8 !== 8'hAA || chg8 !== 1'b0) begin
            n_fail++;
            $display("FAIL en_low_hold: q=%h chg=%b, expected aa 0", q8, chg8);
        end
        mode_wr = 1'b1; mode_in = 2'd2;
        step();
        mode_wr = 1'b0;
        n_checks++;
        if (mode8 !== 2'd2 || q8 !== 8'hAA) begin
            n_fail++;
            $display("FAIL mode_wr_en_low: mode=%0d q=%h, expected 2 aa", mode8, q8);
        end
    endtask

    task automatic test_jk_mode();
        en = 1'b1; a8 = 8'h00; b8 = 8'hAA;
        step();
        n_checks++;
        if (q8 !== 8'h00) begin
            n_fail++;
            $display("FAIL jk_reset_bits: q=%h, expected 00", q8);
        end
        a8 = 8'hF0; b8 = 8'h00;
        step();
        n_checks++;
        if (q8 !== 8'hF0) begin
            n_fail++;
            $display("FAIL jk_set: q=%h, expected f0", q8);
        end
        a8 = 8'h00; b8 = 8'h30;
        step();
        n_checks++;
        if (q8 !== 8'hC0) begin
            n_fail++;
            $display("FAIL jk_clear: q=%h, expected c0", q8);
        end
        a8 = 8'hFF; b8 = 8'hFF;
        step();
        n_checks++;
        if (q8 !== 8'h3F || chg8 !== 1'b1 || sr_err8 !== 1'b0) begin
            n_fail++;
            $display("FAIL jk_toggle: q=%h chg=%b sr_err=%b, expected 3f 1 0", q8, chg8, sr_err8);
        end
    endtask

    task automatic test_sr_mode();
        a8 = 8'h00; b8 = 8'h30;
        step();
        mode_wr = 1'b1; mode_in = 2'd3; a8 = 8'h00; b8 = 8'h00;
        step();
        mode_wr = 1'b0;
        n_checks++;
        if (q8 !== 8'h0F || mode8 !== 2'd3 || chg8 !== 1'b0) begin
            n_fail++;
            $display("FAIL sr_setup: q=%h mode=%0d chg=%b, expected 0f 3 0", q8, mode8, chg8);
        end
        a8 = 8'h81; b8 = 8'h01;
        step();
        n_checks++;
        if (q8 !== 8'h8F || sr_err8 !== 1'b1 || chg8 !== 1'b1) begin
            n_fail++;
            $display("FAIL sr_illegal: q=%h sr_err=%b chg=%b, expected 8f 1 1", q8, sr_err8, chg8);
        end
        a8 = 8'h00; b8 = 8'h00;
        step();
        n_checks++;
        if (sr_err8 !== 1'b1) begin
            n_fail++;
            $display("FAIL sr_err_sticky: sr_err=%b, expected 1", sr_err8);
        end
        clr_err = 1'b1;
        step();
        n_checks++;
        if (sr_err8 !== 1'b0) begin
            n_fail++;
            $display("FAIL sr_err_clear: sr_err=%b, expected 0", sr_err8);
        end
        a8 = 8'h01; b8 = 8'h01;
        step();
        n_checks++;
        if (sr_err8 !== 1'b1 || q8 !== 8'h8F) begin
            n_fail++;
            $display("FAIL sr_set_wins: sr_err=%b q=%h, expected 1 8f", sr_err8, q8);
        end
        clr_err = 1'b0; a8 = 8'h00; b8 = 8'h80;
        step();
        n_checks++;
        if (q8 !== 8'h0F) begin
            n_fail++;
            $display("FAIL sr_reset_bit: q=%h, expected 0f", q8);
        end
        clr_err = 1'b1; b8 = 8'h00;
        step();
        clr_err = 1'b0; en = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
        step();
        n_checks++;
        if (sr_err8 !== 1'b0 || q8 !== 8'h0F) begin
            n_fail++;
            $display("FAIL sr_en_low_no_err: sr_err=%b q=%h, expected 0 0f", sr_err8, q8);
        end
        a8 = 8'h00; b8 = 8'h00;
    endtask

    task automatic test_widths();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (q1 !== 1'b1 || q32 !== 32'hFFFF_FFFF || qn32 !== 32'h0) begin
            n_fail++;
            $display("FAIL wide_reset_val: q1=%b q32=%h qn32=%h, expected 1 ffffffff 0", q1, q32, qn32);
        end
        step();
        rst_n = 1'b1; en = 1'b0; mode_wr = 1'b1; mode_in = 2'd2;
        step();
        mode_wr = 1'b0; en = 1'b1;
        a1 = 1'b1; b1 = 1'b1; a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF;
        step();
        n_checks++;
        if (q1 !== 1'b0 || q32 !== 32'h0 || chg1 !== 1'b1 || chg32 !== 1'b1) begin
            n_fail++;
            $display("FAIL wide_jk_toggle: q1=%b q32=%h chg1=%b chg32=%b, expected 0 0 1 1",
                     q1, q32, chg1, chg32);
        end
        a1 = 1'b0; b1 = 1'b0; a32 = '0; b32 = '0;
    endtask

`ifdef TOGGLE_CNT_EN
    task automatic test_toggle_cnt();
        rst_n = 1'b0; en = 1'b0; clr_err = 1'b0; a8 = 8'h00; b8 = 8'h00;
        #1;
        n_checks++;
        if (cnt8 !== 16'h0) begin
            n_fail++;
            $display("FAIL cnt_reset: cnt=%h, expected 0000", cnt8);
        end
        step();
        rst_n = 1'b1; en = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            a8 = (i % 2 == 0) ? 8'hFF : 8'h00;
            step();
            if (i == 9) begin
                n_checks++;
                if (cnt8 !== 16'd10) begin
                    n_fail++;
                    $display("FAIL cnt_count10: cnt=%0d, expected 10", cnt8);
                end
            end
        end
        n_checks++;
        if (cnt8 !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL cnt_saturate: cnt=%h, expected ffff", cnt8);
        end
        clr_err = 1'b1; a8 = ~q8;
        step();
        n_checks++;
        if (cnt8 !== 16'h0 || chg8 !== 1'b1) begin
            n_fail++;
            $display("FAIL cnt_clear_wins: cnt=%h chg=%b, expected 0000 1", cnt8, chg8);
        end
        clr_err = 1'b0; a8 = ~q8;
        step();
        n_checks++;
        if (cnt8 !== 16'h1) begin
            n_fail++;
            $display("FAIL cnt_resume: cnt=%h, expected 0001", cnt8);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_d_mode();
        test_t_mode();
        test_jk_mode();
        test_sr_mode();
        test_widths();
`ifdef TOGGLE_CNT_EN
        test_toggle_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
